// File: rtl/psram_frame_writer.sv
// Packs an RGB332 byte stream into 16-bit words, buffers them and writes fixed-length
// bursts linearly into PSRAM. Optional test-pattern source: PSRAM_FRAME_WRITER_PATTERN_EN.
module psram_frame_writer #(
   parameter int FRAME_WORDS = 240000,
   parameter int BURST_LEN   = 128,
   parameter int FIFO_DEPTH  = 256
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
`ifdef PSRAM_FRAME_WRITER_PATTERN_EN
   input  logic                          pattern_en,
`endif
   input  logic                          ctrlr_good,
   input  logic                          op_begun,
   input  logic                          data_ok,
   output logic                          req_access,
   output logic                          wr,
   output logic                          burst,
   output logic [22:0]                   addr,
   output logic [15:0]                   wr_data,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [2:0]                    dbg_state,
   output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FILL = 3'd1,
      REQ       = 3'd2,
      WAIT_OK   = 3'd3,
      BURST     = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t state, state_next;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          fifo_full;
   logic          push, wr_en, pop;
   logic [15:0]   push_data;

   logic          pending;
   logic [7:0]    low_byte;
   logic          byte_ok;
   logic          byte_push;

   logic [18:0]   addr_cnt;
   logic          addr_last;
   logic [BW-1:0] beat;

   assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
   assign byte_ok   = in_valid & in_ready;
   assign byte_push = byte_ok & pending;
   assign pop       = (state == BURST) & data_ok;
   assign wr_en     = push & ~fifo_full;
   assign addr_last = (addr_cnt == 19'(FRAME_WORDS - 1));

`ifdef PSRAM_FRAME_WRITER_PATTERN_EN
   logic [18:0] pattern_cnt;
   logic        pat_push;

   // The pattern source owns the FIFO input, so the byte port is held off meanwhile.
   assign in_ready  = ~pattern_en & ~(pending & fifo_full);
   assign pat_push  = pattern_en & ~fifo_full;
   assign push      = byte_push | pat_push;
   assign push_data = pat_push ? {pattern_cnt[7:0] + 8'd1, pattern_cnt[7:0]}
                               : {in_data, low_byte};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern_cnt <= '0;
      end else if (pat_push) begin
         pattern_cnt <= (pattern_cnt == 19'(FRAME_WORDS - 1)) ? '0 : pattern_cnt + 19'd1;
      end
   end
`else
   assign in_ready  = ~(pending & fifo_full);
   assign push      = byte_push;
   assign push_data = {in_data, low_byte};
`endif

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pending  <= 1'b0;
         low_byte <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (byte_ok) begin
            pending <= ~pending;
            if (!pending) low_byte <= in_data;
         end
         // Sticky: a completed word arrived with no room for it.
         if (push && fifo_full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_cnt   <= '0;
         beat       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop & addr_last;
         if (pop) addr_cnt <= addr_last ? '0 : addr_cnt + 19'd1;
         if (state == DONE) beat <= '0;
         else if (pop)      beat <= beat + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_access = 1'b0;
      wr         = 1'b0;
      burst      = 1'b0;
      case (state)
         IDLE: begin
            if (ctrlr_good) state_next = WAIT_FILL;
         end
         WAIT_FILL: begin
            if (count >= (AW+1)'(BURST_LEN)) state_next = REQ;
         end
         REQ: begin
            req_access = 1'b1;
            wr         = 1'b1;
            if (op_begun) state_next = WAIT_OK;
         end
         WAIT_OK: begin
            req_access = 1'b1;
            if (data_ok) state_next = BURST;
         end
         BURST: begin
            req_access = 1'b1;
            burst      = 1'b1;
            if (data_ok && beat == BW'(BURST_LEN - 1)) state_next = DONE;
         end
         DONE: begin
            state_next = ctrlr_good ? WAIT_FILL : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign wr_data        = burst ? mem[rd_ptr] : 16'h0000;
   assign addr           = {4'b0000, addr_cnt};
   assign dbg_state      = state;
   assign dbg_fifo_count = count;

endmodule

// File: tb/tb_psram_frame_writer.sv
// Directed bench for psram_frame_writer: bring-up burst, data_ok stalls, input
// backpressure, frame wrap (short frame) and reset in the middle of a burst.
module tb_psram_frame_writer;

   localparam int FW    = 320;
   localparam int BLEN  = 128;
   localparam int DEPTH = 256;

   logic        clk;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        ctrlr_good;
   logic        op_begun;
   logic        data_ok;
   logic        req_access;
   logic        wr;
   logic        burst;
   logic [22:0] addr;
   logic [15:0] wr_data;
   logic        frame_done;
   logic        overflow;
   logic [2:0]  dbg_state;
   logic [8:0]  dbg_fifo_count;
`ifdef PSRAM_FRAME_WRITER_PATTERN_EN
   logic        pattern_en;
   initial pattern_en = 1'b0;
`endif

   psram_frame_writer #(.FRAME_WORDS(FW), .BURST_LEN(BLEN), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
`ifdef PSRAM_FRAME_WRITER_PATTERN_EN
      .pattern_en     (pattern_en),
`endif
      .ctrlr_good     (ctrlr_good),
      .op_begun       (op_begun),
      .data_ok        (data_ok),
      .req_access     (req_access),
      .wr             (wr),
      .burst          (burst),
      .addr           (addr),
      .wr_data        (wr_data),
      .frame_done     (frame_done),
      .overflow       (overflow),
      .dbg_state      (dbg_state),
      .dbg_fifo_count (dbg_fifo_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  src_q[$];
   logic [15:0] exp_q[$];
   int  cyc = 0;
   int  exp_addr = 0;
   bit  fd_next = 0;
   int  fd_count = 0;
   bit  op_hold = 0;
   bit  tog_mode = 0;
   bit  tog = 0;
   int  accepted = 0;
   int  last_acc_cyc = 0;
   int  req_rise_cyc = -1;
   bit  req_prev = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] byte_val(input int i, input int kind);
      case (kind)
         0:       byte_val = 8'(i);
         1:       byte_val = 8'(i * 37 + 11);
         default: byte_val = 8'(i) ^ 8'h5A;
      endcase
   endfunction

   // queue a byte stream and the words it must turn into
   task automatic queue_bytes(input int n, input int kind);
      logic [7:0] b, prev;
      prev = 8'h00;
      for (int i = 0; i < n; i++) begin
         b = byte_val(i, kind);
         src_q.push_back(b);
         if (i % 2 == 1) exp_q.push_back({b, prev});
         prev = b;
      end
   endtask

   // one clock: check outputs of this cycle, model the controller, drive the byte source
   task automatic tick();
      logic [15:0] w;
      @(negedge clk);
      cyc++;
      check("frame_done", frame_done, fd_next);
      if (frame_done) fd_count++;
      if (req_access && !req_prev && req_rise_cyc < 0) req_rise_cyc = cyc;
      req_prev = req_access;
      if (burst) check("addr", addr, exp_addr);

      op_begun = req_access && wr && !op_hold;
      if (req_access && !wr) begin
         data_ok = tog_mode ? tog : 1'b1;
         tog = !tog;
      end else begin
         data_ok = 1'b0;
      end

      fd_next = 0;
      if (burst && data_ok) begin
         if (exp_q.size() == 0) begin
            check("underrun", 1, 0);
         end else begin
            w = exp_q.pop_front();
            check("wr_data", wr_data, w);
         end
         fd_next = (exp_addr == FW - 1);
         exp_addr = (exp_addr == FW - 1) ? 0 : exp_addr + 1;
      end

      in_valid = (src_q.size() > 0);
      in_data  = in_valid ? src_q[0] : 8'h00;
      if (in_valid && in_ready) begin
         void'(src_q.pop_front());
         accepted++;
         last_acc_cyc = cyc;
      end
   endtask

   task automatic run_until_idle(input string tag, input int max_cyc);
      bit done;
      done = 0;
      for (int k = 0; k < max_cyc && !done; k++) begin
         tick();
         if (src_q.size() == 0 && exp_q.size() == 0 && dbg_state == 3'd1) done = 1;
      end
      if (!done) check({tag, "_timeout"}, 1, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},      req_access,     0);
      check({tag, "_wr"},       wr,             0);
      check({tag, "_burst"},    burst,          0);
      check({tag, "_addr"},     addr,           0);
      check({tag, "_wr_data"},  wr_data,        0);
      check({tag, "_fdone"},    frame_done,     0);
      check({tag, "_overflow"}, overflow,       0);
      check({tag, "_in_ready"}, in_ready,       1);
      check({tag, "_count"},    dbg_fifo_count, 0);
      check({tag, "_state"},    dbg_state,      0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      op_begun = 1'b0;
      data_ok  = 1'b0;
      src_q.delete();
      exp_q.delete();
      exp_addr = 0;
      fd_next  = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      bit seen;
      reset_n = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      ctrlr_good = 1'b0;
      op_begun = 1'b0;
      data_ok = 1'b0;
      #2;
      apply_reset();
      check_reset_outputs("reset");

      // controller not ready: stays IDLE
      repeat (3) tick();
      check("idle_hold_state", dbg_state, 0);

      // bring-up: 256 bytes 0x00..0xFF -> one burst 0x0100..0xFFFE at addr 0..127
      ctrlr_good = 1'b1;
      queue_bytes(256, 0);
      run_until_idle("bringup", 1000);
      check("bringup_req_latency", 32'(req_rise_cyc - last_acc_cyc), 2);
      check("bringup_addr_end", addr, 128);

      // data_ok toggling stalls the burst
      tog_mode = 1;
      queue_bytes(256, 1);
      run_until_idle("stall", 2000);
      check("stall_addr_end", addr, 256);
      check("stall_count", dbg_fifo_count, 0);
      tog_mode = 0;

      // backpressure: controller never begins the write
      op_hold = 1;
      accepted = 0;
      queue_bytes(1024, 2);
      repeat (600) tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_count", dbg_fifo_count, DEPTH);
      check("bp_accepted", accepted, 513);
      check("bp_wr_held", wr, 1);
      check("bp_req_held", req_access, 1);
      check("bp_overflow", overflow, 0);
      op_hold = 0;
      run_until_idle("bp_drain", 4000);
      check("bp_overflow_end", overflow, 0);

      // 768 words so far across a 320-word frame: two wraps
      check("wrap_pulses", fd_count, 2);
      check("wrap_addr_end", addr, 768 - 2 * FW);

      // reset in the middle of a burst
      tog_mode = 1;
      queue_bytes(256, 0);
      seen = 0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         tick();
         if (burst) seen = 1;
      end
      if (!seen) check("midreset_timeout", 1, 0);
      repeat (20) tick();
      check("midreset_in_burst", burst, 1);
      apply_reset();
      check_reset_outputs("midreset");
      tog_mode = 0;

      // fresh burst after reset starts at address 0
      queue_bytes(256, 2);
      run_until_idle("postreset", 1000);
      check("postreset_addr_end", addr, 128);
      check("postreset_overflow", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
